// File: rtl/secuenciador_movimientos_2048.sv
// Move sequencer for the 4x4 2048 board: one line slid and merged per cycle,
// then a pseudo-random tile spawn and a win/lose check. Owns the board register.
module secuenciador_movimientos_2048 #(
    parameter int unsigned VALOR_GANAR  = 11,
    parameter logic [15:0] SEMILLA_LFSR = 16'hACE1
) (
    input  logic        reloj,
    input  logic        reinicio,
    input  logic        comando_valido,
    input  logic [1:0]  comando,
    input  logic        carga_valida,
    input  logic [63:0] carga_tablero,
    output logic        comando_listo,
    output logic [63:0] tablero,
    output logic [1:0]  estado_juego,
    output logic [15:0] puntaje,
    output logic        movimiento_terminado
);
    localparam int unsigned ANCHO_CELDA = 4;
    localparam int unsigned ANCHO_TAB   = 16 * ANCHO_CELDA;
    localparam int unsigned ANCHO_PTS   = 16;
    localparam int unsigned ANCHO_SUMA  = 18;

    typedef enum logic [2:0] {
        INICIO, ESPERA, DESPLAZAR, EVALUAR, GENERAR, VERIFICAR, GANAR, PERDER
    } estado_t;

    estado_t                    estado_q, estado_d;
    logic [ANCHO_TAB-1:0]       tablero_q, tablero_d;
    logic [1:0]                 juego_q, juego_d;
    logic [ANCHO_PTS-1:0]       puntaje_q, puntaje_d;
    logic [15:0]                lfsr_q, lfsr_d;
    logic [1:0]                 dir_q, dir_d;
    logic [1:0]                 linea_q, linea_d;
    logic                       cambio_q, cambio_d;
    logic [3:0]                 cand_q, cand_d;
    logic [3:0]                 cuenta_q, cuenta_d;
    logic                       listo_q, listo_d;
    logic                       fin_q, fin_d;

    logic [3:0]                 idx   [4];
    logic [3:0]                 orig  [4];
    logic [3:0]                 comp  [5];
    logic [3:0]                 nueva [4];
    logic [ANCHO_SUMA-1:0]      suma;
    logic [ANCHO_SUMA-1:0]      pts_ext;
    logic [2:0]                 pos;
    logic [1:0]                 o;
    logic                       salto;
    logic                       hay_ganador;
    logic                       hay_jugada;

    function automatic logic [3:0] celda(input logic [63:0] t, input logic [1:0] f,
                                         input logic [1:0] c);
        return t[{f, c, 2'b00} +: 4];
    endfunction

    // Position p of line i, counted from the edge the tiles slide toward.
    function automatic logic [3:0] indice(input logic [1:0] dir, input logic [1:0] i,
                                          input logic [1:0] p);
        case (dir)
            2'b00:   return {p, i};
            2'b01:   return {~p, i};
            2'b10:   return {i, p};
            default: return {i, ~p};
        endcase
    endfunction

    // Slide and merge of the current line.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            idx[p]  = indice(dir_q, linea_q, 2'(p));
            orig[p] = tablero_q[{idx[p], 2'b00} +: 4];
        end
        for (int p = 0; p < 5; p++) comp[p] = '0;
        pos = '0;
        for (int p = 0; p < 4; p++) begin
            if (orig[p] != '0) begin
                comp[pos] = orig[p];
                pos       = pos + 3'd1;
            end
        end
        for (int p = 0; p < 4; p++) nueva[p] = '0;
        suma  = '0;
        o     = '0;
        salto = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (salto) begin
                salto = 1'b0;
            end else if (comp[k] != '0 && comp[k] == comp[k+1]) begin
                nueva[o] = (comp[k] == 4'hF) ? 4'hF : comp[k] + 4'd1;
                suma     = suma + (18'd1 << (5'(comp[k]) + 5'd1));
                o        = o + 2'd1;
                salto    = 1'b1;
            end else begin
                nueva[o] = comp[k];
                o        = o + 2'd1;
            end
        end
    end

    // Whole-board scans for the win threshold and for any remaining move.
    always_comb begin
        hay_ganador = 1'b0;
        hay_jugada  = 1'b0;
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (celda(tablero_q, 2'(f), 2'(c)) >= 4'(VALOR_GANAR)) hay_ganador = 1'b1;
                if (celda(tablero_q, 2'(f), 2'(c)) == 4'd0) hay_jugada = 1'b1;
                if (c < 3 && celda(tablero_q, 2'(f), 2'(c)) == celda(tablero_q, 2'(f), 2'(c + 1)))
                    hay_jugada = 1'b1;
                if (f < 3 && celda(tablero_q, 2'(f), 2'(c)) == celda(tablero_q, 2'(f + 1), 2'(c)))
                    hay_jugada = 1'b1;
            end
        end
    end

    always_comb begin
        estado_d  = estado_q;
        tablero_d = tablero_q;
        juego_d   = juego_q;
        puntaje_d = puntaje_q;
        lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        dir_d     = dir_q;
        linea_d   = linea_q;
        cambio_d  = cambio_q;
        cand_d    = cand_q;
        cuenta_d  = cuenta_q;
        fin_d     = 1'b0;
        pts_ext   = ANCHO_SUMA'(puntaje_q) + suma;
        case (estado_q)
            INICIO: begin
                tablero_d[{lfsr_q[3:0], 2'b00} +: 4] = 4'd1;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (carga_valida) begin
                    tablero_d = carga_tablero;
                end else if (comando_valido) begin
                    dir_d    = comando;
                    cambio_d = 1'b0;
                    linea_d  = 2'd0;
                    estado_d = DESPLAZAR;
                end
            end
            DESPLAZAR: begin
                for (int p = 0; p < 4; p++) begin
                    tablero_d[{idx[p], 2'b00} +: 4] = nueva[p];
                    if (nueva[p] != orig[p]) cambio_d = 1'b1;
                end
                puntaje_d = (pts_ext > 18'h0FFFF) ? 16'hFFFF : pts_ext[15:0];
                linea_d   = linea_q + 2'd1;
                if (linea_q == 2'd3) estado_d = EVALUAR;
            end
            EVALUAR: begin
                if (!cambio_q) begin
                    fin_d    = 1'b1;
                    estado_d = ESPERA;
                end else if (hay_ganador) begin
                    juego_d  = 2'b01;
                    fin_d    = 1'b1;
                    estado_d = GANAR;
                end else begin
                    cand_d   = lfsr_q[3:0];
                    cuenta_d = 4'd0;
                    estado_d = GENERAR;
                end
            end
            GENERAR: begin
                // Walk forward from the random candidate until an empty cell turns up.
                if (tablero_q[{cand_q, 2'b00} +: 4] == 4'd0) begin
                    tablero_d[{cand_q, 2'b00} +: 4] = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
                    estado_d = VERIFICAR;
                end else if (cuenta_q == 4'hF) begin
                    estado_d = VERIFICAR;
                end else begin
                    cand_d   = cand_q + 4'd1;
                    cuenta_d = cuenta_q + 4'd1;
                end
            end
            VERIFICAR: begin
                fin_d = 1'b1;
                if (hay_jugada) begin
                    estado_d = ESPERA;
                end else begin
                    juego_d  = 2'b10;
                    estado_d = PERDER;
                end
            end
            GANAR, PERDER: begin
                estado_d = estado_q;
            end
            default: estado_d = ESPERA;
        endcase
        listo_d = (estado_d == ESPERA);
    end

    always_ff @(posedge reloj) begin
        if (reinicio) begin
            estado_q  <= INICIO;
            tablero_q <= '0;
            juego_q   <= 2'b00;
            puntaje_q <= '0;
            lfsr_q    <= SEMILLA_LFSR;
            dir_q     <= 2'b00;
            linea_q   <= 2'd0;
            cambio_q  <= 1'b0;
            cand_q    <= 4'd0;
            cuenta_q  <= 4'd0;
            listo_q   <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            tablero_q <= tablero_d;
            juego_q   <= juego_d;
            puntaje_q <= puntaje_d;
            lfsr_q    <= lfsr_d;
            dir_q     <= dir_d;
            linea_q   <= linea_d;
            cambio_q  <= cambio_d;
            cand_q    <= cand_d;
            cuenta_q  <= cuenta_d;
            listo_q   <= listo_d;
            fin_q     <= fin_d;
        end
    end

    assign comando_listo        = listo_q;
    assign tablero              = tablero_q;
    assign estado_juego         = juego_q;
    assign puntaje              = puntaje_q;
    assign movimiento_terminado = fin_q;

endmodule

// File: tb/tb_secuenciador_movimientos_2048.sv
// Directed bench for the 2048 move sequencer with a queue-based board model.
module tb_secuenciador_movimientos_2048;
    logic        reloj = 1'b0;
    logic        reinicio = 1'b1;
    logic        comando_valido = 1'b0;
    logic [1:0]  comando = 2'b00;
    logic        carga_valida = 1'b0;
    logic [63:0] carga_tablero = '0;
    logic        comando_listo;
    logic [63:0] tablero;
    logic [1:0]  estado_juego;
    logic [15:0] puntaje;
    logic        movimiento_terminado;

    int          n_vec = 0;
    int          n_err = 0;
    logic        chk_en = 1'b0;
    logic [63:0] exp_tab = '0;
    logic [15:0] exp_pts = '0;
    logic [1:0]  exp_est = '0;
    logic        exp_listo = 1'b0;
    logic        exp_fin = 1'b0;
    logic [15:0] tb_lfsr;

    secuenciador_movimientos_2048 dut (
        .reloj(reloj), .reinicio(reinicio), .comando_valido(comando_valido),
        .comando(comando), .carga_valida(carga_valida), .carga_tablero(carga_tablero),
        .comando_listo(comando_listo), .tablero(tablero), .estado_juego(estado_juego),
        .puntaje(puntaje), .movimiento_terminado(movimiento_terminado)
    );

    always #5 reloj = ~reloj;

    function automatic logic [15:0] paso(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    always @(posedge reloj) tb_lfsr <= reinicio ? 16'hACE1 : paso(tb_lfsr);

    task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] esp);
        n_vec++;
        if (act !== esp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nombre, act, esp);
        end
    endtask

    always @(negedge reloj) begin
        if (chk_en) begin
            chk("tablero", tablero, exp_tab);
            chk("puntaje", 64'(puntaje), 64'(exp_pts));
            chk("estado_juego", 64'(estado_juego), 64'(exp_est));
            chk("comando_listo", 64'(comando_listo), 64'(exp_listo));
            chk("movimiento_terminado", 64'(movimiento_terminado), 64'(exp_fin));
        end
    end

    function automatic int cel(input logic [1:0] dir, input int i, input int p);
        case (dir)
            2'b00:   return p * 4 + i;
            2'b01:   return (3 - p) * 4 + i;
            2'b10:   return i * 4 + p;
            default: return i * 4 + 3 - p;
        endcase
    endfunction

    function automatic int leer(input logic [63:0] t, input int n);
        return int'(t[n*4 +: 4]);
    endfunction

    function automatic logic [63:0] poner(input logic [63:0] t, input int n, input int v);
        logic [63:0] r;
        r = t;
        r[n*4 +: 4] = 4'(v);
        return r;
    endfunction

    // Reference move: each line becomes a queue of tiles, merged front to back.
    function automatic void mover(input logic [63:0] tab, input logic [1:0] dir,
                                  output logic [63:0] res, output longint gan);
        int q[$];
        int v;
        int r;
        res = tab;
        gan = 0;
        for (int i = 0; i < 4; i++) begin
            q.delete();
            for (int p = 0; p < 4; p++) begin
                v = leer(tab, cel(dir, i, p));
                if (v != 0) q.push_back(v);
            end
            for (int p = 0; p < 4; p++) begin
                if (q.size() >= 2 && q[0] == q[1]) begin
                    v = q[0];
                    r = (v == 15) ? 15 : v + 1;
                    gan += longint'(1) << (v + 1);
                    void'(q.pop_front());
                    void'(q.pop_front());
                end else if (q.size() > 0) begin
                    r = q.pop_front();
                end else begin
                    r = 0;
                end
                res = poner(res, cel(dir, i, p), r);
            end
        end
    endfunction

    function automatic bit jugable(input logic [63:0] t);
        bit ok;
        ok = 0;
        for (int f = 0; f < 4; f++)
            for (int c = 0; c < 4; c++) begin
                if (leer(t, f*4 + c) == 0) ok = 1;
                if (c < 3 && leer(t, f*4 + c) == leer(t, f*4 + c + 1)) ok = 1;
                if (f < 3 && leer(t, f*4 + c) == leer(t, (f+1)*4 + c)) ok = 1;
            end
        return ok;
    endfunction

    // Expected result of a move accepted when the LFSR (just after acceptance) is l0.
    function automatic void esperar(input logic [63:0] tab, input logic [1:0] dir,
                                    input logic [15:0] l0, input logic [15:0] pts_in,
                                    output logic [63:0] tab_o, output logic [15:0] pts_o,
                                    output logic [1:0] est_o, output int lat);
        logic [63:0] m;
        longint      gan;
        longint      tot;
        logic [15:0] l;
        int          cand;
        int          n;
        bit          hecho;
        bit          gana;
        mover(tab, dir, m, gan);
        tot   = longint'(pts_in) + gan;
        pts_o = (tot > 65535) ? 16'hFFFF : 16'(tot);
        tab_o = m;
        est_o = 2'b00;
        lat   = 5;
        gana  = 0;
        for (int n2 = 0; n2 < 16; n2++) if (leer(m, n2) >= 11) gana = 1;
        if (m == tab) begin
            pts_o = pts_in;
        end else if (gana) begin
            est_o = 2'b01;
        end else begin
            l = l0;
            repeat (4) l = paso(l);
            cand  = int'(l[3:0]);
            lat   = 22;
            hecho = 0;
            for (int k = 0; k < 16; k++) begin
                l = paso(l);
                n = (cand + k) % 16;
                if (!hecho && leer(tab_o, n) == 0) begin
                    tab_o = poner(tab_o, n, (l[7:4] == 4'd0) ? 2 : 1);
                    lat   = 7 + k;
                    hecho = 1;
                end
            end
            est_o = jugable(tab_o) ? 2'b00 : 2'b10;
        end
    endfunction

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic reset_seq();
        chk_en = 1'b0;
        reinicio = 1'b1;
        comando_valido = 1'b0;
        carga_valida = 1'b0;
        tick();
        reinicio = 1'b0;
        chk("rst_tablero", tablero, 64'h0);
        chk("rst_puntaje", 64'(puntaje), 64'h0);
        chk("rst_estado", 64'(estado_juego), 64'h0);
        chk("rst_listo", 64'(comando_listo), 64'h0);
        chk("rst_terminado", 64'(movimiento_terminado), 64'h0);
        tick();
        chk("inicio_tablero", tablero, 64'h10);
        chk("inicio_listo", 64'(comando_listo), 64'h1);
        exp_tab = 64'h10; exp_pts = '0; exp_est = 2'b00; exp_listo = 1'b1; exp_fin = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic carga(input logic [63:0] b);
        carga_valida = 1'b1;
        carga_tablero = b;
        tick();
        carga_valida = 1'b0;
        exp_tab = b;
    endtask

    task automatic jugar(input logic [1:0] dir);
        logic [63:0] t_o;
        logic [15:0] p_o;
        logic [1:0]  e_o;
        int          lat;
        int          c;
        comando_valido = 1'b1;
        comando = dir;
        tick();
        comando_valido = 1'b0;
        chk_en = 1'b0;
        esperar(exp_tab, dir, tb_lfsr, exp_pts, t_o, p_o, e_o, lat);
        c = 0;
        while (!movimiento_terminado && c < 40) begin
            chk("ocupado_listo", 64'(comando_listo), 64'h0);
            tick();
            c++;
        end
        chk("latencia", 64'(c), 64'(lat));
        exp_tab = t_o; exp_pts = p_o; exp_est = e_o;
        exp_listo = (e_o == 2'b00); exp_fin = 1'b1;
        chk_en = 1'b1;
        tick();
        exp_fin = 1'b0;
        if (e_o != 2'b00) begin
            comando_valido = 1'b1;
            carga_valida = 1'b1;
            carga_tablero = '1;
            repeat (4) tick();
            comando_valido = 1'b0;
            carga_valida = 1'b0;
        end
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_seq();
        repeat (2) tick();

        carga(64'h2211);
        jugar(2'b10);
        chk("lit_fila0_izq", 64'(tablero[7:0]), 64'h32);
        chk("lit_pts_12", 64'(puntaje), 64'd12);
        chk("lit_est_juego", 64'(estado_juego), 64'h0);

        reset_seq();
        carga(64'h0111);
        jugar(2'b11);
        chk("lit_fila0_der", 64'(tablero[15:8]), 64'h21);
        chk("lit_pts_4", 64'(puntaje), 64'd4);
        jugar(2'b00);
        jugar(2'b01);

        reset_seq();
        carga(64'h0001);
        jugar(2'b10);
        chk("lit_sin_cambio", tablero, 64'h1);
        chk("lit_pts_0", 64'(puntaje), 64'd0);

        reset_seq();
        carga(64'h0000_0000_0001_0001);
        jugar(2'b01);
        jugar(2'b00);

        reset_seq();
        carga(64'h0300_0200_0000_0200);
        jugar(2'b00);
        chk("lit_pts_arriba", 64'(puntaje), 64'd8);
        jugar(2'b11);

        reset_seq();
        carga(64'h00AA);
        jugar(2'b10);
        chk("lit_gana_celda", 64'(tablero[3:0]), 64'hB);
        chk("lit_gana_pts", 64'(puntaje), 64'd2048);
        chk("lit_gana_estado", 64'(estado_juego), 64'h1);

        reset_seq();
        carga(64'hFFFF);
        jugar(2'b10);
        chk("lit_sat_fila", 64'(tablero[15:0]), 64'h00FF);
        chk("lit_sat_pts", 64'(puntaje), 64'hFFFF);

        reset_seq();
        carga(64'h5656_6565_5656_5650);
        jugar(2'b10);
        chk("lit_pierde_fila", 64'(tablero[11:0]), 64'h565);
        chk("lit_pierde_estado", 64'(estado_juego), 64'h2);
        chk("lit_pierde_listo", 64'(comando_listo), 64'h0);

        reset_seq();
        carga(64'h2211);
        comando_valido = 1'b1;
        comando = 2'b10;
        tick();
        comando_valido = 1'b0;
        chk_en = 1'b0;
        repeat (2) tick();
        reset_seq();
        repeat (2) tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/secuenciador_movimientos_2048.md
Name: secuenciador_movimientos_2048

Overview:
Move sequencer for the 4x4 2048 board. It accepts one direction command at a time and processes one board line per cycle: slide, merge once, write back. It then spawns a new tile at a pseudo-random empty cell and checks for win or lose. It owns the board register and feeds the VGA drawing path.

Parameters:
VALOR_GANAR, 11, tile exponent that wins the game (2^11 = 2048)
SEMILLA_LFSR, 16'hACE1, LFSR value loaded at reset (must be nonzero)

Ports:
reloj  input  1  clock; all logic on its rising edge
reinicio  input  1  synchronous, active-high reset
comando_valido  input  1  a move command is presented
comando  input  2  move direction: 00 up, 01 down, 10 left, 11 right
carga_valida  input  1  preload request for the board (test and debug)
carga_tablero  input  64  board image to preload
comando_listo  output  1  high only in ESPERA; a command or load is accepted when its valid and this are both high
tablero  output  64  board; cell (fila,columna) is bits [(fila*4+columna)*4 +: 4]; 0 = empty, v = tile 2^v
estado_juego  output  2  00 playing, 01 won, 10 lost
puntaje  output  16  score, saturating
movimiento_terminado  output  1  one-cycle pulse when a command finishes

Behaviour:
- Reset (reinicio high at an edge): tablero 0, estado_juego 00, puntaje 0, comando_listo 0, movimiento_terminado 0, lfsr=SEMILLA_LFSR, state INICIO. Reset wins over everything, including mid-move; one cycle clears everything.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every non-reset cycle.
- INICIO (1 cycle): cell index lfsr[3:0] (idx = fila*4+columna) gets 1 -> ESPERA.
- ESPERA:
  - comando_listo=1.
  - carga_valida has priority: tablero<=carga_tablero, estado and puntaje unchanged, stay in ESPERA.
  - Otherwise comando_valido latches comando, clears the change flag and sets line counter=0 -> DESPLAZAR.
  - Inputs are ignored in every other state.
- DESPLAZAR (exactly 4 cycles, line i=0..3):
  - Line cells are ordered starting from the destination edge:
    - up: column i, rows 0..3
    - down: column i, rows 3..0
    - left: row i, columns 0..3
    - right: row i, columns 3..0
  - Compress nonzero cells toward position 0.
  - Scan from position 0; merge each equal adjacent pair once. The merged value is v+1 (saturating at 15); the next scan starts after the pair, so a merged result never merges again.
  - Each merge adds 2^(v+1) to puntaje, saturating at 16'hFFFF.
  - Pad with zeros and write the line back at the end of that cycle. Set the change flag if the line differs.
- After line 3:
  - No change: pulse movimiento_terminado -> ESPERA. No spawn, score unchanged.
  - Any cell >= VALOR_GANAR: estado_juego<=01 -> GANAR.
  - Otherwise: candidate<=lfsr[3:0] -> GENERAR.
- GENERAR (1 to 16 cycles):
  - If the candidate cell is empty, write 2 if lfsr[7:4]==0, else 1 -> VERIFICAR.
  - Otherwise candidate<=candidate+1 mod 16.
  - After 16 cells checked with no empty cell, go to VERIFICAR without writing (unreachable after a real change, but required).
- VERIFICAR (1 cycle): pulse movimiento_terminado.
  - Any empty cell, or any horizontally or vertically adjacent equal pair -> ESPERA.
  - Otherwise estado_juego<=10 -> PERDER.
- GANAR/PERDER: terminal until reinicio. comando_listo=0 and movimiento_terminado pulses in the cycle of entry.
- Latency: accept at edge T; lines written at T+1..T+4. No-change pulse is at T+5. Otherwise GENERAR starts at T+5, VERIFICAR follows the spawn, and the total is at most T+22.
- Unused states decode to ESPERA.

Test Plan:
- Reset, then release -> one cycle later the board has exactly one nonzero cell, index 1 (row 0, col 1) = 1; estado 00; comando_listo goes high the next cycle.
- Load row0 [1,1,2,2], rest 0; command left -> row0 [2,3,x,x] with one new 1 or 2 in an empty cell; puntaje 12; movimiento_terminado pulses once; estado 00.
- Load row0 [1,1,1,0], rest 0; command right -> row0 columns 3,2 = 2,1; puntaje 4; exactly one new tile in an empty cell.
- Load row0 [1,0,0,0], rest 0; command left -> board unchanged, no spawn, puntaje unchanged, pulse 5 cycles after acceptance, back to ESPERA.
- Load row0 [10,10,0,0]; command left -> cell (0,0)=11, puntaje 2048, estado 01; later commands ignored; reinicio clears the board and estado.
- Load rows [0,5,6,5],[6,5,6,5],[5,6,5,6],[6,5,6,5]; command left -> row0 [5,6,5,n], n in {1,2}; estado 10; comando_listo stays 0.
- Reset asserted during DESPLAZAR -> the next cycle shows all outputs at their reset values.
